// File: rtl/uart_rx_multi_pkg.sv
// Shared definitions for the multi-rate UART receiver: FSM states, rate codes,
// parity modes and the rate-code to baud table.
package uart_rx_multi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam logic [2:0] BAUD_1200   = 3'd0;
    localparam logic [2:0] BAUD_2400   = 3'd1;
    localparam logic [2:0] BAUD_4800   = 3'd2;
    localparam logic [2:0] BAUD_9600   = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    // Unused codes fall back to 9600 baud.
    function automatic int unsigned baud_to_rate(input logic [2:0] code);
        case (code)
            BAUD_1200:   return 1200;
            BAUD_2400:   return 2400;
            BAUD_4800:   return 4800;
            BAUD_9600:   return 9600;
            BAUD_115200: return 115200;
            default:     return 9600;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_multi_baud_sel.sv
// Combinational rate-code to clocks-per-bit lookup; each divide is a
// constant, so only a small mux is built.
module uart_baud_sel
    import uart_rx_multi_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned CW     = 16
) (
    input  logic [2:0]    baud_code,
    output logic [CW-1:0] clocks_per_bit
);

    localparam int unsigned CPB_1200   = CLK_HZ / baud_to_rate(BAUD_1200);
    localparam int unsigned CPB_2400   = CLK_HZ / baud_to_rate(BAUD_2400);
    localparam int unsigned CPB_4800   = CLK_HZ / baud_to_rate(BAUD_4800);
    localparam int unsigned CPB_9600   = CLK_HZ / baud_to_rate(BAUD_9600);
    localparam int unsigned CPB_115200 = CLK_HZ / baud_to_rate(BAUD_115200);

    always_comb begin
        case (baud_code)
            BAUD_1200:   clocks_per_bit = CW'(CPB_1200);
            BAUD_2400:   clocks_per_bit = CW'(CPB_2400);
            BAUD_4800:   clocks_per_bit = CW'(CPB_4800);
            BAUD_115200: clocks_per_bit = CW'(CPB_115200);
            default:     clocks_per_bit = CW'(CPB_9600);
        endcase
    end

endmodule

// File: rtl/uart_rx_multi.sv
// Multi-rate UART receiver: 2-flop synchroniser, mid-bit sampling FSM,
// optional parity, 1-2 stop bits, held output word with sticky overrun.
module uart_rx_multi
    import uart_rx_multi_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clkRx,
    input  logic                 reset,
    input  logic                 serialInput,
    input  logic [2:0]           baudRate,
    input  logic [1:0]           parity,
    output logic [DATA_BITS-1:0] data,
    output logic                 dataValid,
    input  logic                 dataReady,
    output logic                 parityError,
    output logic                 framingError,
    output logic                 overrun
);

    localparam int unsigned CW        = $clog2(CLK_HZ / 1200 + 1);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

    rx_state_t             state, next_state;
    logic                  sync_meta, line;
    logic [CW-1:0]         clk_count, cpb_sel, cpb_q, bit_last, half_point;
    logic [3:0]            bit_index;
    logic [1:0]            par_q;
    logic [DATA_BITS-1:0]  shift;
    logic                  par_err_q, frame_err_q;
    logic                  bit_done, par_en, commit;

    uart_baud_sel #(
        .CLK_HZ (CLK_HZ),
        .CW     (CW)
    ) u_baud_sel (
        .baud_code      (baudRate),
        .clocks_per_bit (cpb_sel)
    );

    always_comb begin
        bit_last   = cpb_q - CW'(1);
        half_point = bit_last >> 1;
        bit_done   = (clk_count == bit_last);
        par_en     = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
        next_state = state;
        commit     = 1'b0;
        case (state)
            ST_IDLE:   if (!line) next_state = ST_START;
            ST_START:  if (clk_count == half_point) next_state = line ? ST_IDLE : ST_DATA;
            ST_DATA:   if (bit_done && bit_index == LAST_DATA)
                           next_state = par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_done) next_state = ST_STOP;
            ST_STOP:   if (bit_done && bit_index == LAST_STOP) begin
                           next_state = ST_IDLE;
                           commit     = 1'b1;
                       end
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkRx) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clkRx) begin
        if (reset) begin
            sync_meta    <= 1'b1;
            line         <= 1'b1;
            clk_count    <= '0;
            bit_index    <= '0;
            cpb_q        <= '0;
            par_q        <= PAR_NONE;
            shift        <= '0;
            par_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            data         <= '0;
            dataValid    <= 1'b0;
            parityError  <= 1'b0;
            framingError <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sync_meta <= serialInput;
            line      <= sync_meta;

            if (state == ST_IDLE || next_state != state || bit_done) clk_count <= '0;
            else                                                     clk_count <= clk_count + CW'(1);

            if (next_state != state)
                bit_index <= '0;
            else if (bit_done && (state == ST_DATA || state == ST_STOP))
                bit_index <= bit_index + 4'd1;

            // Rate and parity mode are frozen for the whole frame at start detect.
            if (state == ST_IDLE && !line) begin
                cpb_q       <= cpb_sel;
                par_q       <= parity;
                par_err_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end

            if (bit_done) begin
                case (state)
                    ST_DATA:   shift <= {line, shift[DATA_BITS-1:1]};
                    ST_PARITY: par_err_q <= (^shift ^ line) ^ (par_q == PAR_ODD);
                    ST_STOP:   if (!line) frame_err_q <= 1'b1;
                    default:   ;
                endcase
            end

            // A commit keeps dataValid high even when the old word is consumed.
            if (commit) begin
                data         <= shift;
                parityError  <= par_err_q;
                framingError <= frame_err_q | ~line;
                dataValid    <= 1'b1;
                if (dataValid && !dataReady) overrun <= 1'b1;
            end else if (dataValid && dataReady) begin
                dataValid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_multi.md
UART_RX_MULTI -- requirements
Module: uart_rx_multi

Interface
REQ-001 Parameter CLK_HZ, default 50000000, receiver clock frequency in Hz.
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame; legal 5..9.
REQ-003 Parameter STOP_BITS, default 1, stop bits checked per frame; legal 1 or 2.
REQ-004 clkRx  in  1  single receiver clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 serialInput  in  1  asynchronous line; idle high; LSB first.
REQ-007 baudRate  in  3  rate code: 0=1200, 1=2400, 2=4800, 3=9600, 4=115200; 5..7 map to 9600.
REQ-008 parity  in  2  mode: 0=none, 1=odd, 2=even, 3=none.
REQ-009 data  out  DATA_BITS  last received payload, valid while dataValid high.
REQ-010 dataValid  out  1  held-word flag; high until consumed.
REQ-011 dataReady  in  1  consumer accept; word consumed in any cycle where dataValid and dataReady are both high.
REQ-012 parityError  out  1  parity mismatch status of the held word.
REQ-013 framingError  out  1  stop-bit low status of the held word.
REQ-014 overrun  out  1  sticky: a frame completed while the previous word was unconsumed.

Function
REQ-015 serialInput passes a 2-flop synchroniser; all sampling uses the synchronised value (2-cycle input latency).
REQ-016 clocksPerBit = CLK_HZ / selected baud (integer division); baudRate and parity are latched on IDLE->START and held for the whole frame.
REQ-017 States: IDLE, START, DATA, PARITY, STOP; encoding from shared package.
REQ-018 IDLE: clkCount=0, bitIndex=0; synchronised line low -> START.
REQ-019 START: at clkCount == (clocksPerBit-1)/2 line low -> DATA with clkCount=0; line high -> IDLE (glitch rejection, no output change).
REQ-020 DATA: sample at clkCount == clocksPerBit-1, store into shift register at bitIndex, clkCount=0; after bit DATA_BITS-1 -> PARITY if parity mode odd/even, else STOP.
REQ-021 PARITY: sample one bit at same spacing; error if XOR(payload, parity bit) is 0 for odd or 1 for even.
REQ-022 STOP: sample STOP_BITS bits at same spacing; any sampled low sets frame framing flag; after last stop sample -> IDLE same cycle as word commit.
REQ-023 Commit (last stop sample): data, parityError, framingError load, dataValid=1; if dataValid was 1 and not consumed that cycle, overrun=1 and the new word replaces the old.
REQ-024 Simultaneous commit and consume: new word loads, dataValid stays 1, overrun unchanged.
REQ-025 Framing error does not suppress commit; receiver returns to IDLE and waits for line low.
REQ-026 overrun clears only on reset.
REQ-027 clkCount width sized for CLK_HZ/1200; no wrap within a legal frame.

Reset
REQ-028 On reset: state IDLE, clkCount=0, bitIndex=0, data=0, dataValid=0, parityError=0, framingError=0, overrun=0, synchroniser flops=1.
REQ-029 Reset mid-frame abandons the frame with no commit; reset has priority over commit and consume in the same cycle.

Structure
REQ-030 Shared package holds state encodings, baud-code and parity-mode constants, and the baud-to-rate table.
REQ-031 One sub-module uart_baud_sel: combinational baudRate + CLK_HZ -> clocksPerBit.

Verification (CLK_HZ=1152000: 115200 -> 10 clocks/bit, 9600 -> 120)
REQ-032 Code 4, no parity, send 0xA5, dataReady=0 -> dataValid=1, data=0xA5, parityError=0, framingError=0.
REQ-033 Code 4, even parity, send 0x07 with parity bit 0 -> parityError=1; resend with parity bit 1 -> parityError=0.
REQ-034 Code 3, send 0x3C with stop bit low -> data=0x3C, framingError=1; next clean frame 0x11 decodes with framingError=0.
REQ-035 Code 4, 4-cycle low pulse on idle line -> stays IDLE, dataValid remains 0.
REQ-036 Code 4, two frames 0x01, 0x02, dataReady=0 -> data=0x02, overrun=1; dataReady=1 one cycle -> dataValid=0, overrun stays 1.
REQ-037 Assert reset mid-DATA of frame 0x55 -> all outputs 0, next frame 0x66 decodes correctly.
